// File: rtl/display_scan_ctrl_if.sv
// Display scan controller bus.
//
// Groups the per-frame display request (digit nibbles, enables, decimal points,
// blink and leading-zero blanking controls) with the multiplexed drive outputs.
//
//   number      hex nibbles, digit i at [4i+3:4i]
//   AN_ON       per-digit enable (1 = digit may light)
//   dp_in       per-digit decimal point request
//   blink       per-digit blink enable
//   lz_blank    leading-zero blanking enable
//   AN          anode selects (polarity set by the controller)
//   sevenSeg    segments {g,f,e,d,c,b,a}
//   DP          decimal point segment
//   frame_done  one-cycle pulse at the end of each frame
//
// master: the side issuing display requests; slave: the scan controller.
interface display_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8
) ();
    logic [4*NUM_DIGITS-1:0] number;
    logic [NUM_DIGITS-1:0]   AN_ON;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   AN;
    logic [6:0]              sevenSeg;
    logic                    DP;
    logic                    frame_done;

    modport master (
        output number, AN_ON, dp_in, blink, lz_blank,
        input  AN, sevenSeg, DP, frame_done
    );

    modport slave (
        input  number, AN_ON, dp_in, blink, lz_blank,
        output AN, sevenSeg, DP, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment display scan controller.
//
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus. Each digit
// owns a slot of REFRESH_DIV cycles whose first GHOST_BLANK cycles keep every
// anode off to suppress ghosting. Display requests are latched once per frame
// so a frame is always drawn from one consistent snapshot. Digits can be
// disabled, blinked (phase toggles every BLINK_FRAMES frames, starting "off")
// or leading-zero blanked; such digits still consume their slot so brightness
// stays independent of content. All drive outputs are registered.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    display_scan_ctrl_if.slave (requests in, AN/sevenSeg/DP/frame_done out)
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_BLANK  = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input logic                clk,
    input logic                reset,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GHOST_END  = PW'(GHOST_BLANK);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Inactive levels; XOR with these converts active-high internals to pin polarity.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};

    // Hex to segments, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Scan state
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Per-frame snapshot of the display request
    logic [4*NUM_DIGITS-1:0] num_sh_q, num_sh_d;
    logic [NUM_DIGITS-1:0]   an_on_sh_q, an_on_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic                    lz_sh_q, lz_sh_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic slot_end;
    logic frame_end;
    logic frame_start;

    // Snapshot as seen by this cycle's decode: in the capture cycle the live
    // request is used so the frame's very first cycle is already consistent.
    logic [4*NUM_DIGITS-1:0] num_eff;
    logic [NUM_DIGITS-1:0]   an_on_eff;
    logic [NUM_DIGITS-1:0]   dp_eff;
    logic [NUM_DIGITS-1:0]   blink_eff;
    logic                    lz_eff;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [3:0]            nib;
    logic                  visible;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_raw;
    logic [6:0]            seg_raw;
    logic                  dp_raw;

    // Slot / frame sequencing
    always_comb begin
        slot_end    = (presc_q == PRESC_LAST);
        frame_end   = slot_end && (idx_q == IDX_LAST);
        frame_start = (presc_q == '0) && (idx_q == '0);

        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Frame snapshot
    always_comb begin
        num_eff   = frame_start ? bus.number   : num_sh_q;
        an_on_eff = frame_start ? bus.AN_ON    : an_on_sh_q;
        dp_eff    = frame_start ? bus.dp_in    : dp_sh_q;
        blink_eff = frame_start ? bus.blink    : blink_sh_q;
        lz_eff    = frame_start ? bus.lz_blank : lz_sh_q;

        num_sh_d   = num_eff;
        an_on_sh_d = an_on_eff;
        dp_sh_d    = dp_eff;
        blink_sh_d = blink_eff;
        lz_sh_d    = lz_eff;
    end

    // Leading-zero mask: digit i is blanked when it and every higher digit is zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (num_eff[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_eff & zero_above & (i != 0);
        end
    end

    // Current slot decode
    always_comb begin
        nib     = num_eff[4*idx_q +: 4];
        visible = an_on_eff[idx_q]
                & ~(blink_eff[idx_q] & ~blink_on_q)
                & ~lz_mask[idx_q];
        lit     = visible && (presc_q >= GHOST_END);

        an_raw = '0;
        if (lit) begin
            an_raw[idx_q] = 1'b1;
        end
        seg_raw = lit ? hex_to_seg(nib) : 7'h00;
        dp_raw  = lit & dp_eff[idx_q];

        an_d         = an_raw ^ AN_OFF;
        seg_d        = seg_raw ^ SEG_OFF;
        dp_d         = dp_raw ^ ACTIVE_LOW;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b0;
            num_sh_q     <= '0;
            an_on_sh_q   <= '0;
            dp_sh_q      <= '0;
            blink_sh_q   <= '0;
            lz_sh_q      <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= ACTIVE_LOW;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            num_sh_q     <= num_sh_d;
            an_on_sh_q   <= an_on_sh_d;
            dp_sh_q      <= dp_sh_d;
            blink_sh_q   <= blink_sh_d;
            lz_sh_q      <= lz_sh_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.sevenSeg   = seg_q;
    assign bus.DP         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: a cycle-count reference model predicts the
// registered outputs each cycle into a queue; a negedge monitor pops and compares.
module tb_display_scan_ctrl;

    localparam int ND = 8;
    localparam int RD = 8;
    localparam int GB = 2;
    localparam int BF = 2;
    localparam bit AL = 1'b1;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          fd;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GHOST_BLANK (GB),
        .BLINK_FRAMES(BF),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: everything follows from cycles elapsed since reset release.
    int              cyc;
    logic [4*ND-1:0] sh_num;
    logic [ND-1:0]   sh_on, sh_dp, sh_blink;
    logic            sh_lz;

    always @(posedge clk) begin : model
        out_t e;
        int   presc, slot, frame;
        bit   vis, allz;
        e.an  = {ND{AL}};
        e.seg = {7{AL}};
        e.dp  = AL;
        e.fd  = 1'b0;
        if (reset) begin
            cyc      = 0;
            sh_num   = '0;
            sh_on    = '0;
            sh_dp    = '0;
            sh_blink = '0;
            sh_lz    = 1'b0;
        end else begin
            presc = cyc % RD;
            slot  = (cyc / RD) % ND;
            frame = cyc / (RD * ND);
            if (presc == 0 && slot == 0) begin
                sh_num   = bus.number;
                sh_on    = bus.AN_ON;
                sh_dp    = bus.dp_in;
                sh_blink = bus.blink;
                sh_lz    = bus.lz_blank;
            end
            vis = sh_on[slot];
            // Blink "off" is the even half-periods counted from reset.
            if (sh_blink[slot] && ((frame / BF) % 2 == 0)) vis = 1'b0;
            if (sh_lz && slot > 0) begin
                allz = 1'b1;
                for (int j = slot; j < ND; j++) begin
                    if (sh_num[4*j +: 4] != 4'h0) allz = 1'b0;
                end
                if (allz) vis = 1'b0;
            end
            if (vis && presc >= GB) begin
                e.an[slot] = ~AL;
                e.seg      = SEG_TAB[sh_num[4*slot +: 4]] ^ {7{AL}};
                e.dp       = sh_dp[slot] ^ AL;
            end
            e.fd = (presc == RD - 1) && (slot == ND - 1);
            cyc++;
        end
        exp_q.push_back(e);
    end

    // Monitor
    always @(negedge clk) begin : monitor
        out_t e, a;
        logic [ND-1:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.AN, bus.sevenSeg, bus.DP, bus.frame_done};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got AN=%b seg=%h DP=%b fd=%b, want AN=%b seg=%h DP=%b fd=%b",
                         $time, a.an, a.seg, a.dp, a.fd, e.an, e.seg, e.dp, e.fd);
            end
            act = bus.AN ^ {ND{AL}};
            n_tests++;
            if ($countones(act) > 1 || ((bus.DP ^ AL) && act == '0)) begin
                n_fail++;
                $display("FAIL onehot_dp @%0t: got AN=%b DP=%b, want <=1 active anode and DP only with an anode",
                         $time, bus.AN, bus.DP);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [4*ND-1:0] num, input logic [ND-1:0] on,
                         input logic [ND-1:0] dp, input logic [ND-1:0] bl, input logic lz);
        bus.number   = num;
        bus.AN_ON    = on;
        bus.dp_in    = dp;
        bus.blink    = bl;
        bus.lz_blank = lz;
    endtask

    initial begin : stim
        logic [4*ND-1:0] num, mask;
        int k;
        reset = 1'b1;
        drive($urandom, 8'hFF, 8'hFF, 8'h00, 1'b0);
        cycles(3);

        // Fixed pattern, partial enables
        drive(32'h2400_0042, 8'b0011_1100, 8'h04, 8'h00, 1'b0);
        reset = 1'b0;
        cycles(2 * RD * ND);

        // Leading-zero blanking
        drive(32'h0000_0042, 8'hFF, 8'h02, 8'h00, 1'b1);
        cycles(2 * RD * ND);

        // Blink on digit 0 over several half-periods, restarted from reset
        reset = 1'b1;
        cycles(1);
        drive($urandom, 8'hFF, 8'h01, 8'h01, 1'b0);
        reset = 1'b0;
        cycles(5 * RD * ND);

        // Reset pulsed during slot 3
        cycles(3 * RD + 3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        drive(32'h89AB_CDEF, 8'hFF, 8'hA5, 8'h00, 1'b0);
        cycles(RD * ND + 5);

        // Random requests changed at arbitrary points, including mid-frame
        for (int it = 0; it < 30; it++) begin
            k    = $urandom_range(0, ND);
            mask = (k == ND) ? '0 : ({4*ND{1'b1}} >> (4 * k));
            num  = $urandom & mask;
            drive(num, ND'($urandom), ND'($urandom), ND'($urandom), 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 2));
                reset = 1'b0;
            end
            cycles($urandom_range(1, 90));
        end

        cycles(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
